// File: rtl/imsic_pkg.sv
// Shared constants, types and helpers for the IMSIC MSI register map.
package imsic_pkg;

  localparam logic [31:0] IMSIC_M_BASE      = 32'h2400_0000;
  localparam logic [31:0] IMSIC_S_BASE      = 32'h2800_0000;
  localparam logic [31:0] IMSIC_FILE_STRIDE = 32'h0000_1000;

  localparam logic [31:0] SETEIPNUM_LE_OFF  = 32'h0000_0000;
  localparam logic [31:0] SETEIPNUM_BE_OFF  = 32'h0000_0004;
  localparam logic [31:0] DROP_CNT_OFF      = 32'h0000_0FF0;

  localparam int IMSIC_NR_SRC = 64;

  // Identity type for the default identity count.
  typedef logic [$clog2(IMSIC_NR_SRC)-1:0] msi_id_t;

  // Kind of register targeted by the current bus access.
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_LE,
    ACC_BE,
    ACC_CNT
  } acc_kind_e;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Synchronous FIFO buffering MSI identities for one interrupt file.
module imsic_msi_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         i_clk,
  input  logic         ni_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign o_valid = (count_q != '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_data  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = i_pop && o_valid;
  assign do_push = i_push && (!o_full || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!ni_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count gates o_valid, so stale entries are never presented.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/imsic_msi_fifo_regmap.sv
// IMSIC seteipnum register map with per-file MSI FIFOs.
// Optional drop counter at M-page offset 0xFF0 when IMSIC_DROP_CNT_EN is defined.
module imsic_msi_fifo_regmap
  import imsic_pkg::*;
#(
  parameter int                NR_SRC      = IMSIC_NR_SRC,
  parameter int                NR_VS_FILES = 1,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] M_BASE      = ADDR_W'(IMSIC_M_BASE),
  parameter logic [ADDR_W-1:0] S_BASE      = ADDR_W'(IMSIC_S_BASE),
  parameter logic [ADDR_W-1:0] FILE_STRIDE = ADDR_W'(IMSIC_FILE_STRIDE),
  localparam int               NR_FILES    = 2 + NR_VS_FILES,
  localparam int               ID_W        = $clog2(NR_SRC)
) (
  input  logic                           i_clk,
  input  logic                           ni_rst,
  input  logic                           i_reg_en,
  input  logic                           i_reg_we,
  input  logic [ADDR_W-1:0]              i_reg_addr,
  input  logic [31:0]                    i_reg_wdata,
  output logic                           o_reg_ready,
  output logic [31:0]                    o_reg_rdata,
  output logic [NR_FILES-1:0][ID_W-1:0]  o_msi_id,
  output logic [NR_FILES-1:0]            o_msi_valid,
  input  logic [NR_FILES-1:0]            i_msi_ready,
  output logic                           o_drop
);

  logic [ADDR_W-1:0]   page_off [NR_FILES];
  logic [NR_FILES-1:0] page_hit;
  logic [NR_FILES-1:0] sel_oh;
  logic [ADDR_W-1:0]   sel_off;
  acc_kind_e           acc_kind;

  logic [31:0]         wr_id;
  logic                id_ok;
  logic                msi_wr;
  logic                push_req;
  logic                drop_d, drop_q;

  logic [NR_FILES-1:0] full;
  logic [NR_FILES-1:0] pop;
  logic [NR_FILES-1:0] can_accept;
  logic [NR_FILES-1:0] push;

  // Per-file page decode and identity FIFO.
  for (genvar k = 0; k < NR_FILES; k++) begin : g_file
    localparam logic [ADDR_W-1:0] BASE =
      (k == 0) ? M_BASE : S_BASE + FILE_STRIDE * ADDR_W'(k - 1);

    // Unsigned wrap makes addresses below BASE fail the range test too.
    assign page_off[k] = i_reg_addr - BASE;
    assign page_hit[k] = (page_off[k] < FILE_STRIDE);

    imsic_msi_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ID_W)
    ) u_fifo (
      .i_clk   (i_clk),
      .ni_rst  (ni_rst),
      .i_push  (push[k]),
      .i_data  (wr_id[ID_W-1:0]),
      .o_full  (full[k]),
      .i_pop   (pop[k]),
      .o_valid (o_msi_valid[k]),
      .o_data  (o_msi_id[k])
    );
  end

  // Select the lowest-numbered hitting file and classify the offset.
  always_comb begin
    sel_oh   = '0;
    sel_off  = '0;
    acc_kind = ACC_NONE;
    for (int k = 0; k < NR_FILES; k++) begin
      if (page_hit[k] && (sel_oh == '0)) begin
        sel_oh[k] = 1'b1;
        sel_off   = page_off[k];
      end
    end
    if (sel_oh != '0) begin
      if (sel_off == ADDR_W'(SETEIPNUM_LE_OFF)) begin
        acc_kind = ACC_LE;
      end else if (sel_off == ADDR_W'(SETEIPNUM_BE_OFF)) begin
        acc_kind = ACC_BE;
      end
`ifdef IMSIC_DROP_CNT_EN
      else if (sel_oh[0] && (sel_off == ADDR_W'(DROP_CNT_OFF))) begin
        acc_kind = ACC_CNT;
      end
`endif
    end
  end

  always_comb begin
    wr_id    = (acc_kind == ACC_BE) ? bswap32(i_reg_wdata) : i_reg_wdata;
    id_ok    = (wr_id != 32'd0) && (wr_id < 32'(NR_SRC));
    msi_wr   = i_reg_en && i_reg_we && ((acc_kind == ACC_LE) || (acc_kind == ACC_BE));
    push_req = msi_wr && id_ok;
    drop_d   = msi_wr && !id_ok;
  end

  // Only a valid push into a full FIFO with no same-cycle pop stalls the bus.
  assign pop         = o_msi_valid & i_msi_ready;
  assign can_accept  = ~full | pop;
  assign push        = {NR_FILES{push_req}} & sel_oh & can_accept;
  assign o_reg_ready = i_reg_en && (!push_req || ((sel_oh & can_accept) != '0));
  assign o_drop      = drop_q;

  always_ff @(posedge i_clk) begin
    if (!ni_rst) drop_q <= 1'b0;
    else         drop_q <= drop_d;
  end

`ifdef IMSIC_DROP_CNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        cnt_clr;

  // Saturating count; a clearing write takes priority over an increment.
  always_comb begin
    cnt_clr    = i_reg_en && i_reg_we && (acc_kind == ACC_CNT);
    drop_cnt_d = drop_cnt_q;
    if (cnt_clr) begin
      drop_cnt_d = '0;
    end else if (drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!ni_rst) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign o_reg_rdata = (i_reg_en && !i_reg_we && (acc_kind == ACC_CNT)) ? drop_cnt_q : 32'd0;
`else
  // seteipnum registers are write-only, so every read returns zero.
  assign o_reg_rdata = 32'd0;
`endif

endmodule

// File: tb/tb_imsic_msi_fifo_regmap.sv
// Scoreboard bench for imsic_msi_fifo_regmap: expected identities are queued per file
// at issue time and checked by a monitor whenever a file head is handed over.
module tb_imsic_msi_fifo_regmap;
  import imsic_pkg::*;

  localparam int NR_FILES = 3;
  localparam int ID_W     = 6;
  localparam logic [31:0] M_BASE = 32'h2400_0000;
  localparam logic [31:0] S_BASE = 32'h2800_0000;

  logic                          i_clk = 1'b0;
  logic                          ni_rst;
  logic                          i_reg_en;
  logic                          i_reg_we;
  logic [31:0]                   i_reg_addr;
  logic [31:0]                   i_reg_wdata;
  logic                          o_reg_ready;
  logic [31:0]                   o_reg_rdata;
  logic [NR_FILES-1:0][ID_W-1:0] o_msi_id;
  logic [NR_FILES-1:0]           o_msi_valid;
  logic [NR_FILES-1:0]           i_msi_ready;
  logic                          o_drop;

  always #5 i_clk = ~i_clk;

  imsic_msi_fifo_regmap dut (
    .i_clk       (i_clk),
    .ni_rst      (ni_rst),
    .i_reg_en    (i_reg_en),
    .i_reg_we    (i_reg_we),
    .i_reg_addr  (i_reg_addr),
    .i_reg_wdata (i_reg_wdata),
    .o_reg_ready (o_reg_ready),
    .o_reg_rdata (o_reg_rdata),
    .o_msi_id    (o_msi_id),
    .o_msi_valid (o_msi_valid),
    .i_msi_ready (i_msi_ready),
    .o_drop      (o_drop)
  );

  int      n_vec = 0;
  int      n_err = 0;
  msi_id_t exp_q [NR_FILES][$];
  int      drop_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int stalls);
    i_reg_en    = 1'b1;
    i_reg_we    = 1'b1;
    i_reg_addr  = addr;
    i_reg_wdata = data;
    stalls      = 0;
    @(negedge i_clk);
    while (!o_reg_ready && stalls < 32) begin
      stalls++;
      @(negedge i_clk);
    end
    check($sformatf("wr_ready_%08h", addr), 32'(o_reg_ready), 32'd1);
    tick();
    i_reg_en = 1'b0;
    i_reg_we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    i_reg_en   = 1'b1;
    i_reg_we   = 1'b0;
    i_reg_addr = addr;
    @(negedge i_clk);
    check({name, "_ready"}, 32'(o_reg_ready), 32'd1);
    check({name, "_rdata"}, o_reg_rdata, exp);
    tick();
    i_reg_en = 1'b0;
  endtask

  // Monitor: every head handover and every drop pulse is matched against the model.
  always @(negedge i_clk) begin
    for (int k = 0; k < NR_FILES; k++) begin
      if (o_msi_valid[k] && i_msi_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("unexpected_head_f%0d", k), 32'(o_msi_valid[k]), 32'd0);
        end else begin
          msi_id_t e;
          e = exp_q[k].pop_front();
          check($sformatf("head_id_f%0d", k), 32'(o_msi_id[k]), 32'(e));
        end
      end
    end
    if (o_drop) begin
      if (drop_exp > 0) begin
        drop_exp--;
        check("drop_pulse", 32'(o_drop), 32'd1);
      end else begin
        check("unexpected_drop", 32'(o_drop), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    ni_rst      = 1'b0;
    i_reg_en    = 1'b0;
    i_reg_we    = 1'b0;
    i_reg_addr  = '0;
    i_reg_wdata = '0;
    i_msi_ready = '0;

    // Reset state.
    tick(3);
    @(negedge i_clk);
    check("rst_valid", 32'(o_msi_valid), 32'd0);
    check("rst_drop", 32'(o_drop), 32'd0);
    check("rst_ready_idle", 32'(o_reg_ready), 32'd0);
    check("rst_rdata_idle", o_reg_rdata, 32'd0);
    tick();
    ni_rst = 1'b1;
    tick();

    // LE write to M file: one-cycle latency, then drained.
    exp_q[0].push_back(msi_id_t'(5));
    bus_write(M_BASE, 32'h0000_0005, st);
    @(negedge i_clk);
    check("le_valid", 32'(o_msi_valid), 32'b001);
    check("le_id", 32'(o_msi_id[0]), 32'd5);
    tick();
    i_msi_ready[0] = 1'b1;
    tick();
    i_msi_ready[0] = 1'b0;
    @(negedge i_clk);
    check("le_drained", 32'(o_msi_valid), 32'd0);
    tick();

    // BE write to the guest file.
    exp_q[2].push_back(msi_id_t'(7));
    bus_write(S_BASE + 32'h1004, 32'h0700_0000, st);
    @(negedge i_clk);
    check("be_valid", 32'(o_msi_valid), 32'b100);
    check("be_id", 32'(o_msi_id[2]), 32'd7);
    tick();
    i_msi_ready[2] = 1'b1;
    tick();
    i_msi_ready[2] = 1'b0;
    @(negedge i_clk);
    check("be_drained", 32'(o_msi_valid), 32'd0);
    tick();

    // Range boundaries: 0, 64 and BE 0x01000000 drop; 63 and BE 1 are kept.
    drop_exp++;
    bus_write(M_BASE, 32'd0, st);
    drop_exp++;
    bus_write(M_BASE, 32'd64, st);
    drop_exp++;
    bus_write(M_BASE + 32'h4, 32'h0000_0001, st);
    exp_q[0].push_back(msi_id_t'(63));
    bus_write(M_BASE, 32'd63, st);
    exp_q[0].push_back(msi_id_t'(1));
    bus_write(M_BASE + 32'h4, 32'h0100_0000, st);
    @(negedge i_clk);
    check("drops_outstanding", 32'(drop_exp), 32'd0);
    check("range_valid", 32'(o_msi_valid), 32'b001);
    tick();
    i_msi_ready[0] = 1'b1;
    tick(3);
    i_msi_ready[0] = 1'b0;
    @(negedge i_clk);
    check("range_drained", 32'(exp_q[0].size()), 32'd0);
    tick();
`ifdef IMSIC_DROP_CNT_EN
    read_check("cnt_three", M_BASE + 32'hFF0, 32'd3);
    bus_write(M_BASE + 32'hFF0, 32'hDEAD_BEEF, st);
    read_check("cnt_cleared", M_BASE + 32'hFF0, 32'd0);
`else
    read_check("cnt_unmapped", M_BASE + 32'hFF0, 32'd0);
`endif

    // Backpressure on S file: four fit, fifth stalls until a pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      exp_q[1].push_back(msi_id_t'(11 + i));
      bus_write(S_BASE, 32'(11 + i), st);
      check($sformatf("bp_no_stall_%0d", i), 32'(st), 32'd0);
    end
    exp_q[1].push_back(msi_id_t'(15));
    i_reg_en    = 1'b1;
    i_reg_we    = 1'b1;
    i_reg_addr  = S_BASE;
    i_reg_wdata = 32'd15;
    @(negedge i_clk);
    check("bp_stall_c1", 32'(o_reg_ready), 32'd0);
    tick();
    @(negedge i_clk);
    check("bp_stall_c2", 32'(o_reg_ready), 32'd0);
    tick();
    i_msi_ready[1] = 1'b1;
    @(negedge i_clk);
    check("bp_push_pop_full", 32'(o_reg_ready), 32'd1);
    tick();
    i_reg_en = 1'b0;
    i_reg_we = 1'b0;
    tick(6);
    @(negedge i_clk);
    check("bp_drained_valid", 32'(o_msi_valid), 32'd0);
    check("bp_drained_queue", 32'(exp_q[1].size()), 32'd0);
    tick();
    i_msi_ready[1] = 1'b0;

    // Reset mid-operation discards 1,2,3; only 9 emerges afterwards.
    bus_write(M_BASE, 32'd1, st);
    bus_write(M_BASE, 32'd2, st);
    bus_write(M_BASE, 32'd3, st);
    @(negedge i_clk);
    check("mid_filled", 32'(o_msi_valid), 32'b001);
    tick();
    ni_rst = 1'b0;
    tick();
    ni_rst = 1'b1;
    @(negedge i_clk);
    check("mid_rst_valid", 32'(o_msi_valid), 32'd0);
    tick();
    exp_q[0].push_back(msi_id_t'(9));
    bus_write(M_BASE, 32'd9, st);
    i_msi_ready[0] = 1'b1;
    tick(4);
    @(negedge i_clk);
    check("mid_alone_valid", 32'(o_msi_valid), 32'd0);
    check("mid_alone_queue", 32'(exp_q[0].size()), 32'd0);
    tick();
    i_msi_ready = '0;

    // Reads and unmapped writes.
    read_check("rd_s_le", S_BASE, 32'd0);
    read_check("rd_unmapped", 32'h2000_0000, 32'd0);
    read_check("rd_m_be", M_BASE + 32'h4, 32'd0);
    bus_write(32'h2000_0000, 32'd5, st);
    bus_write(32'h2000_0000, 32'd0, st);
    bus_write(M_BASE + 32'h8, 32'd6, st);
    bus_write(S_BASE + 32'h2000, 32'd7, st);
    tick(2);
    @(negedge i_clk);
    check("unmapped_no_push", 32'(o_msi_valid), 32'd0);
    check("unmapped_no_drop", 32'(drop_exp), 32'd0);
    tick();
`ifdef IMSIC_DROP_CNT_EN
    read_check("cnt_after_unmapped", M_BASE + 32'hFF0, 32'd0);
`endif

    for (int k = 0; k < NR_FILES; k++) begin
      check($sformatf("final_queue_f%0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
